fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
- Round-robin, frame-aware arbiter that drains the read sides of NUM_PORTS ingress FIFOs into one shared output stream in the switch core.
- Grants one FIFO at a time and holds the grant for a whole frame, which ends on a word whose bit DATA_WIDTH-1 (last flag) is set.
- The FIFOs are show-ahead: read data is valid whenever the FIFO is not empty, and a read enable pops one word.
- Includes a frame-length watchdog so a malformed frame cannot lock the output.

Parameters:
NUM_PORTS, 4, number of FIFOs arbitrated (2..16)
DATA_WIDTH, 9, FIFO word width; bit DATA_WIDTH-1 is the last-word flag, bits DATA_WIDTH-2:0 are payload
MAX_FRAME_WORDS, 1518, maximum accepted words per grant before forced release

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-high reset
fifo_empty  input  NUM_PORTS  per-FIFO empty flag
fifo_data  input  NUM_PORTS*DATA_WIDTH  show-ahead FIFO read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
fifo_read_enable  output  NUM_PORTS  per-FIFO pop, at most one bit high
out_data  output  DATA_WIDTH  selected FIFO word, last flag included
out_valid  output  1  out_data valid this cycle
out_ready  input  1  downstream accepts the word when out_valid && out_ready
grant  output  NUM_PORTS  one-hot current owner, 0 when idle
busy  output  1  high in the FORWARD state
frame_error  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, grant=0, rr_ptr=0, word_cnt=0, frame_error=0. Consequently fifo_read_enable=0, out_valid=0 and out_data=0 while idle.
- State machine: IDLE, FORWARD.
- IDLE:
  - Requests are req[i] = !fifo_empty[i].
  - Search order is rr_ptr, rr_ptr+1, ... mod NUM_PORTS; the first requester wins.
  - On a win: register a one-hot grant for the winner, clear word_cnt, move to FORWARD on the next edge.
  - With no requesters, stay in IDLE.
  - Nothing is forwarded in IDLE.
- FORWARD (sel = index of the grant bit), combinational outputs:
  - out_valid = !fifo_empty[sel]
  - out_data = fifo_data[sel]
  - fifo_read_enable[sel] = out_valid && out_ready; all other enables are 0.
- Beat accepted (valid && ready): word_cnt increments.
  - Last flag set: next edge goes to IDLE, grant=0, rr_ptr=(sel+1) mod NUM_PORTS.
  - Last flag clear and word_cnt+1 == MAX_FRAME_WORDS: same release as the last-flag case, plus frame_error=1 for the following cycle only. Remaining words of that frame are later arbitrated as a new frame; no dropping is done here.
  - Last flag set and count limit reached on the same beat: normal release, no error.
- Stalls:
  - The granted FIFO going empty mid-frame drops out_valid and keeps the grant, with no timeout on stalls.
  - out_ready low keeps out_data and out_valid stable as long as the FIFO is unchanged; no pop occurs.
- Latency and throughput:
  - Request to first output beat: 1 cycle (arbitration edge).
  - One mandatory IDLE cycle separates consecutive frames.
  - Throughput within a frame is 1 word per cycle.
- Fairness: a port that just finished has the lowest priority next round. With all ports requesting continuously, grants go 0,1,2,3,0,...
- Single-word frame (last flag on the first word): FORWARD lasts one cycle when ready is high.
- word_cnt width is clog2(MAX_FRAME_WORDS+1) and it never wraps; it is cleared on each grant.
- Reset mid-frame: grant and enables drop asynchronously, the partial frame stays in the FIFO, and rr_ptr returns to 0.
- Requests arriving during FORWARD are ignored until IDLE.
- busy = (state == FORWARD).

Test Plan:
- Reset, then port 2 alone holds 3 words (0x011, 0x022, 0x1AA) with out_ready=1 -> grant=0100 one cycle after the request; out_data 0x011, 0x022, 0x1AA on 3 consecutive cycles with fifo_read_enable=0100; then IDLE with rr_ptr=3.
- All 4 ports hold 2-word frames, ready=1 -> frames emitted in port order 0,1,2,3 with exactly one idle cycle between frames; grant is never multi-hot.
- Port 1 frame of 4 words with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 pops, each only in a cycle with ready=1; out_data stable during stalls.
- Granted port empties after word 2 for 5 cycles, then supplies a last word -> out_valid=0 for those 5 cycles, grant held, frame completes, no frame_error.
- MAX_FRAME_WORDS=4, port 0 sends 6 words with last on the 6th -> 4 words forwarded, then release and frame_error high for 1 cycle; with only port 0 requesting, it is re-granted and words 5 and 6 follow as a new frame.
- Assert reset during word 2 of a 5-word frame -> grant, enables and out_valid go to 0 immediately; after release, port 0 is re-granted and the remaining 3 words are forwarded.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// Round-robin, frame-aware arbiter that drains NUM_PORTS show-ahead FIFOs into one stream.
// A grant is held for a whole frame. A watchdog forces release after MAX_FRAME_WORDS beats.
module fifo_read_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = 9,
  parameter int MAX_FRAME_WORDS = 1518
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]            fifo_read_enable,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic                            frame_error
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_FRAME_WORDS + 1);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t                state, state_next;
  logic [NUM_PORTS-1:0]  grant_next;
  logic [PTR_W-1:0]      rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]      sel, winner;
  logic [PTR_W:0]        idx;
  logic                  found;
  logic [CNT_W-1:0]      word_cnt, word_cnt_next, cnt_inc;
  logic                  frame_error_next;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) sel = PTR_W'(i);
    end
  end

  assign sel_data = fifo_data[sel*DATA_WIDTH +: DATA_WIDTH];

  // Search starts at rr_ptr and wraps, so the port that just finished is checked last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_PORTS)) idx = idx - (PTR_W+1)'(NUM_PORTS);
      if (!found && !fifo_empty[idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    rr_ptr_next      = rr_ptr;
    word_cnt_next    = word_cnt;
    frame_error_next = 1'b0;
    out_valid        = 1'b0;
    out_data         = '0;
    fifo_read_enable = '0;
    accept           = 1'b0;
    cnt_inc          = word_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (found) begin
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          word_cnt_next      = '0;
          state_next         = FORWARD;
        end
      end
      FORWARD: begin
        out_valid             = !fifo_empty[sel];
        out_data              = sel_data;
        accept                = out_valid && out_ready;
        fifo_read_enable[sel] = accept;
        if (accept) begin
          word_cnt_next = cnt_inc;
          // A last flag on the limit beat is a clean frame end, not a watchdog hit.
          if (sel_data[DATA_WIDTH-1] || cnt_inc == CNT_W'(MAX_FRAME_WORDS)) begin
            state_next       = IDLE;
            grant_next       = '0;
            rr_ptr_next      = (sel == PTR_W'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
            frame_error_next = !sel_data[DATA_WIDTH-1];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      word_cnt    <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      rr_ptr      <= rr_ptr_next;
      word_cnt    <= word_cnt_next;
      frame_error <= frame_error_next;
    end
  end

  assign busy = (state == FORWARD);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: queue-based FIFOs, a per-cycle reference of
// round-robin frame ownership, directed scenarios and a randomized run.
module tb_fifo_read_arbiter;
  localparam int N     = 4;
  localparam int W     = 9;
  localparam int MAXW  = 4;
  localparam int DEPTH = 64;

  logic           clk, reset;
  logic [N-1:0]   fifo_empty;
  logic [N*W-1:0] fifo_data;
  logic [N-1:0]   fifo_read_enable;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  logic [N-1:0]   grant;
  logic           busy, frame_error;

  fifo_read_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(W), .MAX_FRAME_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_enable(fifo_read_enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant(grant), .busy(busy), .frame_error(frame_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] mem [N][DEPTH];
  int wr [N];
  int rd [N];
  int m_owner, m_next, m_cnt;
  bit m_err;
  logic [W-1:0] obs_word [$];
  logic [N-1:0] obs_grant [$];
  int obs_cyc [$];
  int ferr_seen, stall_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic update_ports();
    logic [N-1:0]   e;
    logic [N*W-1:0] d;
    e = '0;
    d = '0;
    for (int p = 0; p < N; p++) begin
      e[p] = (wr[p] == rd[p]);
      if (!e[p]) d[p*W +: W] = mem[p][rd[p] % DEPTH];
    end
    fifo_empty = e;
    fifo_data  = d;
  endtask

  task automatic push(input int p, input logic [W-1:0] w);
    mem[p][wr[p] % DEPTH] = w;
    wr[p]++;
    update_ports();
  endtask

  task automatic flush();
    for (int p = 0; p < N; p++) rd[p] = wr[p];
    update_ports();
  endtask

  task automatic clear_logs();
    obs_word.delete();
    obs_grant.delete();
    obs_cyc.delete();
    ferr_seen  = 0;
    stall_seen = 0;
  endtask

  function automatic logic [31:0] obs_w(input int i);
    return (i < obs_word.size()) ? 32'(obs_word[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] obs_g(input int i);
    return (i < obs_grant.size()) ? 32'(obs_grant[i]) : 32'hDEAD;
  endfunction

  function automatic int obs_c(input int i);
    return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
  endfunction

  // Outputs must drop the instant reset rises, before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_read_enable", 32'(fifo_read_enable), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_error", 32'(frame_error), 32'd0);
    m_owner = -1;
    m_next  = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] ren_s, exp_grant, exp_ren;
    logic [W-1:0] head;
    logic         m_valid;
    bit           found;
    int           pe;
    @(negedge clk);
    ren_s     = fifo_read_enable;
    exp_grant = '0;
    exp_ren   = '0;
    head      = '0;
    m_valid   = 1'b0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      m_valid = (wr[m_owner] != rd[m_owner]);
      if (m_valid) head = mem[m_owner][rd[m_owner] % DEPTH];
      if (m_valid && out_ready) exp_ren[m_owner] = 1'b1;
    end
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_data", 32'(out_data), 32'(head));
    check_eq("read_enable", 32'(ren_s), 32'(exp_ren));
    check_eq("frame_error", 32'(frame_error), 32'(m_err));
    if (out_valid && out_ready) begin
      obs_word.push_back(out_data);
      obs_grant.push_back(grant);
      obs_cyc.push_back(cyc);
    end
    if (frame_error) ferr_seen++;
    if (busy && !out_valid) stall_seen++;

    if (m_owner < 0) begin
      m_err = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        pe = (m_next + k) % N;
        if (!found && wr[pe] != rd[pe]) begin
          found   = 1'b1;
          m_owner = pe;
          m_cnt   = 0;
        end
      end
    end else if (m_valid && out_ready) begin
      m_cnt++;
      if (head[W-1] || m_cnt == MAXW) begin
        m_err   = !head[W-1];
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_err = 1'b0;
      end
    end else begin
      m_err = 1'b0;
    end
    cyc++;

    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (ren_s[p] && wr[p] != rd[p]) rd[p]++;
    end
    update_ports();
  endtask

  initial begin
    int c0, pending;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset     = 1'b1;
    out_ready = 1'b0;
    for (int p = 0; p < N; p++) begin
      wr[p] = 0;
      rd[p] = 0;
    end
    update_ports();
    #12;
    do_reset();

    // Single port 2 frame, then check that port 3 is next in line.
    clear_logs();
    out_ready = 1'b1;
    c0 = cyc;
    push(2, 9'h011);
    push(2, 9'h022);
    push(2, 9'h1AA);
    repeat (5) step();
    check_eq("p2_count", 32'(obs_word.size()), 32'd3);
    check_eq("p2_w0", obs_w(0), 32'h011);
    check_eq("p2_w1", obs_w(1), 32'h022);
    check_eq("p2_w2", obs_w(2), 32'h1AA);
    check_eq("p2_grant", obs_g(0), 32'h4);
    check_eq("p2_latency", 32'(obs_c(0) - c0), 32'd1);
    check_eq("p2_back_to_back", 32'(obs_c(2) - obs_c(0)), 32'd2);
    clear_logs();
    push(0, 9'h101);
    push(3, 9'h103);
    repeat (5) step();
    check_eq("rr_after_p2", obs_g(0), 32'h8);
    check_eq("rr_then_p0", obs_g(1), 32'h1);

    // All ports hold 2-word frames.
    flush();
    do_reset();
    clear_logs();
    for (int p = 0; p < N; p++) begin
      push(p, {1'b0, 8'(16*p + 1)});
      push(p, {1'b1, 8'(16*p + 2)});
    end
    repeat (14) step();
    check_eq("all_count", 32'(obs_word.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_eq("all_order", obs_g(i), 32'(1 << (i / 2)));
    check_eq("all_span", 32'(obs_c(7) - obs_c(0)), 32'd10);

    // Backpressure on a frame whose last flag lands on the word limit.
    clear_logs();
    for (int i = 0; i < 4; i++) push(1, {(i == 3), 8'(8'h50 + 8'(i))});
    step();
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      step();
    end
    check_eq("bp_pops", 32'(obs_word.size()), 32'd4);
    check_eq("bp_w3", obs_w(3), 32'h153);
    check_eq("bp_no_error", 32'(ferr_seen), 32'd0);

    // Granted FIFO runs dry mid-frame.
    clear_logs();
    out_ready = 1'b1;
    repeat (2) step();
    clear_logs();
    push(0, 9'h031);
    push(0, 9'h032);
    repeat (8) step();
    push(0, 9'h133);
    repeat (2) step();
    check_eq("stall_cycles", 32'(stall_seen), 32'd5);
    check_eq("stall_words", 32'(obs_word.size()), 32'd3);
    check_eq("stall_last", obs_w(2), 32'h133);
    check_eq("stall_no_error", 32'(ferr_seen), 32'd0);

    // Over-long frame trips the watchdog and the rest follows as a new frame.
    clear_logs();
    for (int i = 0; i < 6; i++) push(0, {(i == 5), 8'(8'h60 + 8'(i))});
    repeat (10) step();
    check_eq("wd_words", 32'(obs_word.size()), 32'd6);
    check_eq("wd_error_pulses", 32'(ferr_seen), 32'd1);
    check_eq("wd_gap", 32'(obs_c(4) - obs_c(3)), 32'd2);
    check_eq("wd_regrant", obs_g(4), 32'h1);
    check_eq("wd_w5", obs_w(5), 32'h165);

    // Reset in the middle of a frame leaves the remainder in the FIFO.
    for (int i = 0; i < 5; i++) push(0, {(i == 4), 8'(8'h41 + 8'(i))});
    repeat (3) step();
    clear_logs();
    do_reset();
    repeat (5) step();
    check_eq("mid_rst_words", 32'(obs_word.size()), 32'd3);
    check_eq("mid_rst_w0", obs_w(0), 32'h043);
    check_eq("mid_rst_w2", obs_w(2), 32'h145);
    check_eq("mid_rst_grant", obs_g(0), 32'h1);

    // Randomized traffic with arbitrary frame lengths, stalls and backpressure.
    for (int t = 0; t < 3000; t++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 3) == 0 && wr[p] - rd[p] < 40)
          push(p, {($urandom_range(0, 3) == 0), 8'($urandom)});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int p = 0; p < N; p++) push(p, 9'h1FF);
    out_ready = 1'b1;
    repeat (400) step();
    pending = 0;
    for (int p = 0; p < N; p++) pending += wr[p] - rd[p];
    check_eq("drain_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
